// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait
// timeout and a sticky TRAP state that only reset can leave.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    input  logic        br_taken_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rd_wren_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_OPIMM, C_OP, C_LOAD, C_STORE, C_BRANCH,
        C_JALR, C_JAL, C_AUIPC, C_LUI, C_ILL
    } cls_t;

    localparam logic [3:0] WAIT_MAX = 4'(TIMEOUT - 1);

    state_t      state, state_n;
    cls_t        dec_cls, cls_q;
    logic [3:0]  wcnt, wcnt_n;
    logic [31:0] instret;
    logic        retire;
    logic        unused_instr;

    assign unused_instr = ^instr_i[31:7];

    function automatic logic [2:0] imm_of(input cls_t c);
        case (c)
            C_OPIMM, C_LOAD, C_JALR: imm_of = 3'd0;
            C_STORE:                 imm_of = 3'd1;
            C_BRANCH:                imm_of = 3'd2;
            C_JAL:                   imm_of = 3'd3;
            C_LUI, C_AUIPC:          imm_of = 3'd4;
            default:                 imm_of = 3'd7;
        endcase
    endfunction

    always_comb begin
        dec_cls = C_ILL;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:2])
                5'b00100: dec_cls = C_OPIMM;
                5'b01100: dec_cls = C_OP;
                5'b00000: dec_cls = C_LOAD;
                5'b01000: dec_cls = C_STORE;
                5'b11000: dec_cls = C_BRANCH;
                5'b11001: dec_cls = C_JALR;
                5'b11011: dec_cls = C_JAL;
                5'b00101: dec_cls = C_AUIPC;
                5'b01101: dec_cls = C_LUI;
                default:  dec_cls = C_ILL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_FETCH;
            cls_q   <= C_OPIMM;
            wcnt    <= 4'd0;
            instret <= 32'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (state == S_DECODE)
                cls_q <= dec_cls;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        imm_sel_o   = 3'd7;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        rd_wren_o   = 1'b0;
        wb_sel_o    = 2'd0;
        illegal_o   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_n = S_DECODE;
                end else if (wcnt == WAIT_MAX) begin
                    state_n = S_TRAP;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            S_DECODE: begin
                // Class is not latched yet; present the immediate from the live decode.
                imm_sel_o = imm_of(dec_cls);
                state_n   = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                imm_sel_o   = imm_of(cls_q);
                alu_a_sel_o = (cls_q == C_AUIPC) || (cls_q == C_JAL) || (cls_q == C_BRANCH);
                alu_b_sel_o = (cls_q != C_OP);
                case (cls_q)
                    C_BRANCH: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = br_taken_i;
                        state_n  = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_n = S_MEM;
                    default:         state_n = S_WB;
                endcase
            end
            S_MEM: begin
                imm_sel_o  = imm_of(cls_q);
                dmem_req_o = 1'b1;
                dmem_we_o  = (cls_q == C_STORE);
                if (dmem_ack_i) begin
                    if (cls_q == C_STORE) begin
                        pc_we_o = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wcnt == WAIT_MAX) begin
                    state_n = S_TRAP;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            S_WB: begin
                imm_sel_o = imm_of(cls_q);
                rd_wren_o = 1'b1;
                pc_we_o   = 1'b1;
                pc_sel_o  = (cls_q == C_JAL) || (cls_q == C_JALR);
                wb_sel_o  = (cls_q == C_LOAD) ? 2'd1 :
                            ((cls_q == C_JAL) || (cls_q == C_JALR)) ? 2'd2 : 2'd0;
                state_n   = S_FETCH;
            end
            S_TRAP:  illegal_o = 1'b1;
            default: state_n = S_TRAP;
        endcase
        // Any state change clears the wait count, so FETCH and MEM start from zero.
        if (state_n != state)
            wcnt_n = 4'd0;
        if (rst_i) begin
            imem_req_o  = 1'b0;
            dmem_req_o  = 1'b0;
            dmem_we_o   = 1'b0;
            ir_we_o     = 1'b0;
            pc_we_o     = 1'b0;
            pc_sel_o    = 1'b0;
            imm_sel_o   = 3'd7;
            alu_a_sel_o = 1'b0;
            alu_b_sel_o = 1'b0;
            rd_wren_o   = 1'b0;
            wb_sel_o    = 2'd0;
            illegal_o   = 1'b0;
        end
    end

    assign retire    = (state_n == S_FETCH) &&
                       ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));
    assign state_o   = state;
    assign instret_o = instret;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of consecutive request cycles without an acknowledge before a trap.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port instr_i, input, 32: instruction register contents, stable from DECODE onward.
REQ-005 SHALL have port imem_ack_i, input, 1: instruction memory read data valid.
REQ-006 SHALL have port dmem_ack_i, input, 1: data memory access complete.
REQ-007 SHALL have port br_taken_i, input, 1: branch comparator result, valid in EXEC.
REQ-008 SHALL have port imem_req_o, output, 1: instruction fetch request.
REQ-009 SHALL have port dmem_req_o, output, 1: data memory request.
REQ-010 SHALL have port dmem_we_o, output, 1: data memory write.
REQ-011 SHALL have port ir_we_o, output, 1: instruction register load strobe.
REQ-012 SHALL have port pc_we_o, output, 1: PC update strobe.
REQ-013 SHALL have port pc_sel_o, output, 1: PC source (0 = PC+4, 1 = ALU result).
REQ-014 SHALL have port imm_sel_o, output, 3: immediate format (0 I, 1 S, 2 B, 3 J, 4 U, 7 none).
REQ-015 SHALL have port alu_a_sel_o, output, 1: ALU operand A source (0 = rs1, 1 = PC).
REQ-016 SHALL have port alu_b_sel_o, output, 1: ALU operand B source (0 = rs2, 1 = immediate).
REQ-017 SHALL have port rd_wren_o, output, 1: register file write enable.
REQ-018 SHALL have port wb_sel_o, output, 2: writeback source (0 ALU, 1 load data, 2 PC+4).
REQ-019 SHALL have port state_o, output, 3: current state (FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5).
REQ-020 SHALL have port illegal_o, output, 1: sticky trap flag.
REQ-021 SHALL have port instret_o, output, 32: count of retired instructions.

Function
REQ-022 SHALL decode the opcode class from instr_i[6:2] as follows: 00100 OP-IMM, 01100 OP, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11001 JALR, 11011 JAL, 00101 AUIPC, 01101 LUI.
REQ-023 SHALL treat any other opcode, or instr_i[1:0] != 2'b11, as illegal.
REQ-024 SHALL latch the decoded class in a register at the end of DECODE; EXEC, MEM and WB SHALL use only the latched class.
REQ-025 FETCH SHALL assert imem_req_o; on imem_ack_i it SHALL assert ir_we_o in that same cycle and move to DECODE; an acknowledge in the first request cycle SHALL be accepted.
REQ-026 DECODE SHALL last one cycle, then move to TRAP if the instruction is illegal, otherwise to EXEC.
REQ-027 imm_sel_o SHALL be driven in DECODE through WB per class: OP-IMM/LOAD/JALR I, STORE S, BRANCH B, JAL J, LUI/AUIPC U, OP none; it SHALL be 7 in all other states.
REQ-028 EXEC for BRANCH SHALL drive alu_a_sel_o=1 and alu_b_sel_o=1, pc_we_o=1 and pc_sel_o=br_taken_i, then move to FETCH.
REQ-029 EXEC for LOAD/STORE SHALL move to MEM.
REQ-030 EXEC for all other classes SHALL move to WB.
REQ-031 In EXEC, alu_a_sel_o SHALL be 1 for AUIPC, JAL and BRANCH, and alu_b_sel_o SHALL be 0 only for OP.
REQ-032 MEM SHALL assert dmem_req_o, with dmem_we_o=1 for STORE; on dmem_ack_i a STORE SHALL pulse pc_we_o with pc_sel_o=0 and move to FETCH, and a LOAD SHALL move to WB.
REQ-033 WB SHALL assert rd_wren_o and pc_we_o for one cycle, then move to FETCH.
REQ-034 In WB, wb_sel_o SHALL be 1 for LOAD, 2 for JAL/JALR and 0 otherwise.
REQ-035 In WB, pc_sel_o SHALL be 1 for JAL/JALR and 0 otherwise.
REQ-036 pc_we_o SHALL pulse exactly once per retired instruction.
REQ-037 All strobes not named for a state SHALL be 0 in that state.
REQ-038 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and increment on each request cycle without an acknowledge.
REQ-039 When the wait counter reaches TIMEOUT-1 and the acknowledge is still absent, the FSM SHALL move to TRAP; an acknowledge in the TIMEOUT-th request cycle SHALL be honoured.
REQ-040 TRAP SHALL hold illegal_o=1, drive all strobes to 0, and be left only by reset.
REQ-041 instret_o SHALL increment by 1 in the cycle the FSM returns to FETCH from EXEC, MEM or WB, and SHALL wrap modulo 2^32.
REQ-042 Latency without memory wait: ALU/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.

Reset
REQ-043 While rst_i=1, all strobes and illegal_o SHALL be 0 in that same cycle, and state, class, wait counter and instret_o SHALL be cleared.
REQ-044 The first cycle after rst_i=0 SHALL be FETCH with imem_req_o=1.
REQ-045 Reset asserted in any state, including mid-MEM or TRAP, SHALL abort the operation with no pc_we_o or rd_wren_o pulse.

Verification
REQ-046 ADDI 0x00500093 with immediate acknowledges -> states 0,1,2,4; rd_wren_o=1, wb_sel_o=0, imm_sel_o=0 in cycle 4; instret_o=1.
REQ-047 LW 0x0000A103 with dmem_ack_i 3 cycles after dmem_req_o -> MEM held 3 cycles, then WB with wb_sel_o=1; total 7 cycles.
REQ-048 BEQ 0x00000463 run with br_taken_i=1 and with br_taken_i=0 -> EXEC pc_we_o=1, pc_sel_o=1 and 0 respectively, imm_sel_o=2, rd_wren_o never asserted.
REQ-049 Illegal instruction 0x0000007F -> TRAP after DECODE, illegal_o=1 sticky, instret_o unchanged, cleared by rst_i.
REQ-050 imem_ack_i withheld -> TRAP after 16 request cycles; imem_ack_i given on the 16th cycle -> DECODE, no trap.
REQ-051 rst_i pulsed during MEM of SW 0x00112023 -> dmem_req_o=0 in the reset cycle, FETCH next cycle, instret_o=0.
